// File: rtl/cache_pkg.sv
// cache_pkg: fill FSM state type, default parameters
// and a line-offset helper shared by the fill arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_FILL,
    S_DONE
  } fill_st_e;

  localparam int unsigned DEF_NUM_PORTS = 2;
  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_WPL       = 8;
  localparam int unsigned DEF_MEM_LAT   = 4;

  // Byte-offset bits inside a line of 2-byte words.
  function automatic int unsigned line_bits(
    input int unsigned wpl
  );
    return $clog2(wpl * 2);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: request vector in, one-hot grant out.
// ARB_RR_EN defined: round-robin, search from ptr_q.
// ARB_RR_EN undefined: fixed priority, lowest first.
// Ports: clk, rst (sync, high), req_i, adv_i (grant
// taken this cycle), gnt_o.
module rr_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_PORTS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

`ifdef ARB_RR_EN
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  rot, rg;
  logic [31:0]   sh, shc;

  // Rotate so the pointer slot is bit 0, take the
  // lowest request, rotate the grant back.
  always_comb begin
    sh    = 32'(ptr_q);
    shc   = N - sh;
    rot   = (req_i >> sh) | (req_i << shc);
    rg    = rot & (-rot);
    gnt_o = (rg << sh) | (rg >> shc);
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (adv_i && gnt_o[i]) begin
        ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb gnt_o = req_i & (-req_i);

  logic unused_rr;
  assign unused_rr = ^{clk, rst, adv_i};
`endif

endmodule

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares one memory port between
// N cache miss ports (line fills) and write-through
// stores. Config macro: ARB_RR_EN (round-robin grant).
// Ports: clk, rst (sync, high); miss_req/miss_addr per
// port; wr_req/wr_addr/wr_data, wr_ack; stall per port;
// fill_data_we/fill_tag_we per port, fill_addr,
// fill_data; mem_en/mem_wr/mem_addr/mem_wdata to
// memory, mem_rdata/mem_rvalid back; busy.
module cache_fill_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = DEF_NUM_PORTS,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned WORDS_PER_LINE = DEF_WPL,
  parameter int unsigned MEM_LAT        = DEF_MEM_LAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        miss_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] miss_addr,
  input  logic                        wr_req,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ack,
  output logic [NUM_PORTS-1:0]        stall,
  output logic [NUM_PORTS-1:0]        fill_data_we,
  output logic [NUM_PORTS-1:0]        fill_tag_we,
  output logic [ADDR_W-1:0]           fill_addr,
  output logic [DATA_W-1:0]           fill_data,
  output logic                        mem_en,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_rvalid,
  output logic                        busy
);

  localparam int unsigned CW =
    $clog2(WORDS_PER_LINE) + 1;
  localparam int unsigned OW =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned LS =
    line_bits(WORDS_PER_LINE);
  localparam logic [ADDR_W-1:0] LMASK =
    ~((ADDR_W'(1) << LS) - ADDR_W'(1));
  localparam logic [CW-1:0] WPL =
    CW'(WORDS_PER_LINE);
  localparam logic [CW-1:0] LAST =
    CW'(WORDS_PER_LINE - 1);

  fill_st_e          state_q, state_d;
  logic [OW-1:0]     own_q, own_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     iss_q, iss_d;
  logic [CW-1:0]     ret_q, ret_d;

  logic [NUM_PORTS-1:0] gnt, own_oh;
  logic [OW-1:0]        gnt_idx;
  logic [ADDR_W-1:0]    gnt_addr;
  logic                 grant, issue, ret, last;
  logic                 in_fill;

  assign grant = (state_q == S_IDLE) && !wr_req &&
                 (|miss_req);

  rr_arbiter #(
    .N(NUM_PORTS)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req_i(miss_req),
    .adv_i(grant),
    .gnt_o(gnt)
  );

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        gnt_idx  = OW'(i);
        gnt_addr = miss_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign in_fill = (state_q == S_FILL);
  assign issue   = in_fill && (iss_q < WPL);
  // Returns only count inside FILL, so stale data
  // from an aborted fill never reaches a cache.
  assign ret     = in_fill && mem_rvalid &&
                   (ret_q < WPL);
  assign last    = ret && (ret_q == LAST);
  assign own_oh  = NUM_PORTS'(1) << own_q;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    base_d  = base_q;
    iss_d   = iss_q;
    ret_d   = ret_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          state_d = S_WRITE;
        end else if (grant) begin
          state_d = S_FILL;
          own_d   = gnt_idx;
          base_d  = gnt_addr & LMASK;
          iss_d   = '0;
          ret_d   = '0;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_FILL: begin
        if (issue) iss_d = iss_q + CW'(1);
        if (ret)   ret_d = ret_q + CW'(1);
        if (last)  state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      own_q   <= '0;
      base_q  <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      base_q  <= base_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    wr_ack       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_data_we = '0;
    fill_tag_we  = '0;
    fill_addr    = '0;
    fill_data    = '0;
    if (state_q == S_WRITE) begin
      wr_ack    = 1'b1;
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
    if (issue) begin
      mem_en   = 1'b1;
      mem_addr = base_q + ADDR_W'({iss_q, 1'b0});
    end
    if (ret) begin
      fill_data_we = own_oh;
      fill_addr    = base_q + ADDR_W'({ret_q, 1'b0});
      fill_data    = mem_rdata;
    end
    if (last) fill_tag_we = own_oh;
  end

  assign stall = miss_req |
    ((in_fill || state_q == S_DONE) ? own_oh : '0);
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: random + directed stimulus
// against a transaction-timing reference model.
module tb_cache_fill_arbiter;

  localparam int N   = 2;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int W   = 8;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    miss_req;
  logic [N*AW-1:0] miss_addr;
  logic            wr_req;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wr_ack;
  logic [N-1:0]    stall, fill_data_we, fill_tag_we;
  logic [AW-1:0]   fill_addr, mem_addr;
  logic [DW-1:0]   fill_data, mem_wdata, mem_rdata;
  logic            mem_en, mem_wr, mem_rvalid, busy;

  cache_fill_arbiter #(
    .NUM_PORTS     (N),
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .WORDS_PER_LINE(W),
    .MEM_LAT       (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .miss_req    (miss_req),
    .miss_addr   (miss_addr),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .stall       (stall),
    .fill_data_we(fill_data_we),
    .fill_tag_we (fill_tag_we),
    .fill_addr   (fill_addr),
    .fill_data   (fill_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .busy        (busy)
  );

  // Memory: word array plus fixed-latency read pipe.
  bit [DW-1:0] mem_q [32768];
  bit          mem_v [32768];
  bit          pv_q  [LAT];
  bit [DW-1:0] pd_q  [LAT];

  function automatic logic [DW-1:0] mem_rd(
    input logic [AW-1:0] a
  );
    logic [DW-1:0] h;
    h = (a * 16'h9e37) ^ 16'h5a5a;
    return mem_v[a[AW-1:1]] ? mem_q[a[AW-1:1]] : h;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      mem_q[mem_addr[AW-1:1]] <= mem_wdata;
      mem_v[mem_addr[AW-1:1]] <= 1'b1;
    end
    pv_q[0] <= mem_en && !mem_wr;
    pd_q[0] <= mem_rd(mem_addr);
    for (int i = 1; i < LAT; i++) begin
      pv_q[i] <= pv_q[i-1];
      pd_q[i] <= pd_q[i-1];
    end
  end

  assign mem_rvalid = pv_q[LAT-1];
  assign mem_rdata  = pd_q[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit tmo     = 1'b0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Reference model: per grant, the spec's timing
  // (issue k at g+1+k, return j at g+1+LAT+j, DONE at
  // g+W+LAT+1, IDLE at g+W+LAT+2; write ack at g+1).
  int            idle_at = 0;
  int            ptr = 0;
  bit            f_act, w_act;
  int            f_st, f_own, w_at, e_k, e_j;
  logic [AW-1:0] f_base, w_a;
  logic [DW-1:0] f_dat [W];
  logic [DW-1:0] w_d;
  bit            e_busy, e_ack, e_en, e_wr;
  logic [AW-1:0] e_ma, e_fa;
  logic [DW-1:0] e_wd, e_fd;
  logic [N-1:0]  e_fwe, e_ftw, e_st, oh;
  bit            found;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        idle_at = cyc + 1;
        f_act   = 1'b0;
        w_act   = 1'b0;
        ptr     = 0;
      end else begin
        e_busy = (cyc < idle_at);
        if (!e_busy) begin
          if (wr_req) begin
            w_act   = 1'b1;
            w_at    = cyc + 1;
            w_a     = wr_addr;
            w_d     = wr_data;
            idle_at = cyc + 2;
          end else if (|miss_req) begin
            found = 1'b0;
`ifdef ARB_RR_EN
            for (int s = 0; s < N; s++) begin
              if (!found && miss_req[(ptr + s) % N]) begin
                found = 1'b1;
                f_own = (ptr + s) % N;
              end
            end
            ptr = (f_own + 1) % N;
`else
            for (int s = 0; s < N; s++) begin
              if (!found && miss_req[s]) begin
                found = 1'b1;
                f_own = s;
              end
            end
`endif
            f_act  = 1'b1;
            f_st   = cyc + 1;
            f_base = miss_addr[f_own*AW +: AW] &
                     ~AW'(2 * W - 1);
            for (int j = 0; j < W; j++)
              f_dat[j] = mem_rd(f_base + AW'(2 * j));
            idle_at = cyc + W + LAT + 2;
          end
        end
        e_ack = w_act && (cyc == w_at);
        e_en  = 1'b0;
        e_wr  = 1'b0;
        e_ma  = '0;
        e_wd  = '0;
        e_fwe = '0;
        e_ftw = '0;
        e_fa  = '0;
        e_fd  = '0;
        e_st  = miss_req;
        if (e_ack) begin
          e_en = 1'b1;
          e_wr = 1'b1;
          e_ma = w_a;
          e_wd = w_d;
        end
        if (f_act) begin
          oh        = '0;
          oh[f_own] = 1'b1;
          e_k       = cyc - f_st;
          e_j       = e_k - LAT;
          if (e_k >= 0 && e_k < W) begin
            e_en = 1'b1;
            e_ma = f_base + AW'(2 * e_k);
          end
          if (e_j >= 0 && e_j < W) begin
            e_fwe = oh;
            e_fa  = f_base + AW'(2 * e_j);
            e_fd  = f_dat[e_j];
            if (e_j == W - 1) e_ftw = oh;
          end
          if (e_k >= 0 && e_k <= W + LAT) e_st = e_st | oh;
        end
        chk("busy",      busy,         e_busy);
        chk("wr_ack",    wr_ack,       e_ack);
        chk("mem_en",    mem_en,       e_en);
        chk("mem_wr",    mem_wr,       e_wr);
        chk("mem_addr",  mem_addr,     e_ma);
        chk("mem_wdata", mem_wdata,    e_wd);
        chk("fill_we",   fill_data_we, e_fwe);
        chk("tag_we",    fill_tag_we,  e_ftw);
        chk("fill_addr", fill_addr,    e_fa);
        chk("fill_data", fill_data,    e_fd);
        chk("stall",     stall,        e_st);
        chk("timeout",   tmo,          1'b0);
      end
      cyc++;
    end
  end

  // Ports drop miss_req in the cycle after their tag
  // write; the store drops wr_req after its ack.
  logic [N-1:0] dropped;
  bit           wdrop;

  task automatic tick();
    logic [N-1:0] tg;
    logic         ak;
    @(negedge clk);
    #2;
    tg = fill_tag_we;
    ak = wr_ack;
    @(posedge clk);
    #1;
    dropped  = tg & miss_req;
    miss_req = miss_req & ~tg;
    wdrop    = ak && wr_req;
    if (ak) wr_req = 1'b0;
  endtask

  task automatic raise_miss(
    input int p, input logic [AW-1:0] a
  );
    miss_addr[p*AW +: AW] = a;
    miss_req[p]           = 1'b1;
  endtask

  task automatic raise_wr(
    input logic [AW-1:0] a, input logic [DW-1:0] d
  );
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((busy || (|miss_req) || wr_req) && b < 400)
    begin
      tick();
      b++;
    end
    if (b >= 400) tmo = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    miss_req  = '0;
    miss_addr = '0;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    dropped   = '0;
    wdrop     = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    raise_miss(0, 16'h0046);
    drain();
    tick();

    raise_miss(0, 16'h1230);
    raise_miss(1, 16'h2348);
    for (int b = 0; b < 100 && !dropped[0]; b++) tick();
    tick();
    raise_miss(0, 16'h3452);
    drain();
    tick();

    raise_wr(16'h2350, 16'hbeef);
    raise_miss(1, 16'h2356);
    drain();
    tick();

    raise_miss(0, 16'h4400);
    repeat (4) tick();
    raise_wr(16'h4404, 16'hcafe);
    drain();
    tick();

    raise_miss(0, 16'h0044);
    drain();
    tick();

    raise_miss(0, 16'h5510);
    repeat (6) tick();
    rst      = 1'b1;
    miss_req = '0;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    raise_miss(1, 16'h5510);
    drain();
    tick();

    repeat (3000) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!miss_req[i] && !dropped[i] &&
            $urandom_range(0, 9) == 0)
          raise_miss(i, AW'($urandom));
      end
      if (!wr_req && !wdrop && $urandom_range(0, 19) == 0)
        raise_wr(AW'($urandom), DW'($urandom));
    end
    drain();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
